if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC, issues one-at-a-time requests to instruction memory and presents each returned instruction with its PC+4 to the IF/ID pipeline register.
- Honours branch redirects (`br_taken`/`br_target`) by squashing in-flight and buffered fetches, and honours hazard-unit stalls by holding its output.
- Sits between instruction memory and IF/ID; a bubble is driven as all-zero instruction and PC+4.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_out_buf.sv | 57 +++++
 rtl/if_fetch_unit.sv | 107 ++++++++++
 tb/tb_if_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_out_buf.sv
// IF/ID-facing output buffer: {pc+4, instruction, valid}, zero whenever it holds a bubble.
module fetch_out_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        consume_i,
    input  logic        flush_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // flush beats load beats consume; a load on the consuming edge replaces the old entry
    always_comb begin
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (flush_i) begin
            pc_plus4_d = 32'h0;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else if (load_i) begin
            pc_plus4_d = pc_plus4_i;
            instr_d    = instr_i;
            valid_d    = 1'b1;
        end else if (consume_i) begin
            pc_plus4_d = 32'h0;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_plus4_q <= 32'h0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_plus4_o = pc_plus4_q;
    assign instr_o    = instr_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: one outstanding imem request, branch redirect with kill of stale returns,
// and stall-held output buffer feeding IF/ID.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  pc_plus4;
    logic         buf_load, buf_consume, buf_flush;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        unique case (state_q)
            StReq: begin
                // the request already on the bus cannot be withdrawn, so mark its return stale
                state_d = StWait;
                if (br_taken) begin
                    pc_d   = br_target;
                    kill_d = 1'b1;
                end
            end
            StWait: begin
                if (br_taken) begin
                    pc_d = br_target;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = stall_in ? StHold : StReq;
                    end
                end
            end
            StHold: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = StReq;
                end else if (!stall_in) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == StReq);
        imem_addr   = pc_q;
        buf_flush   = br_taken;
        buf_load    = (state_q == StWait) && imem_rvalid && !kill_q && !br_taken;
        buf_consume = !stall_in;
    end

    fetch_out_buf u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .load_i     (buf_load),
        .consume_i  (buf_consume),
        .flush_i    (buf_flush),
        .pc_plus4_i (pc_plus4),
        .instr_i    (imem_rdata),
        .pc_plus4_o (pc_plus4_out),
        .instr_o    (instruction_out),
        .valid_o    (valid_out)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with variable latency, address and
// output scoreboards, a branch-vector table and hand-written stall/reset sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] pc_plus4_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_rvalid     (imem_rvalid),
        .pc_plus4_out    (pc_plus4_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } out_t;

    typedef struct {
        int          lat;
        bit          in_req;
        bit          stall;
        logic [31:0] target;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
        logic [31:0] exp_next;
    } br_vec_t;

    out_t        exp_out[$];
    logic [31:0] exp_addr[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          mem_lat  = 1;
    logic        pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr;
    logic        prev_valid, prev_stall;
    br_vec_t     vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        if (a == 32'h4) return 32'h2002_0003;
        return a ^ 32'h2400_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: register requests before the edge, then model memory and monitor after it.
    task automatic step();
        out_t e;
        @(negedge clk);
        prev_valid = valid_out;
        prev_stall = stall_in;
        if (!reset && imem_req) begin
            if (exp_addr.size() > 0) check("imem_addr", imem_addr, exp_addr.pop_front());
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = imem_addr;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (reset) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end
        end
        if (valid_out && (!prev_valid || !prev_stall) && exp_out.size() > 0) begin
            e = exp_out.pop_front();
            check("out_pc_plus4", pc_plus4_out, e.pc4);
            check("out_instr", instruction_out, e.instr);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (exp_out.size() > 0 || exp_addr.size() > 0); k++) step();
        check("drain_out_left", exp_out.size(), 0);
        check("drain_addr_left", exp_addr.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'h0, valid_out}, 32'h0);
        check({tag, "_pc4"}, pc_plus4_out, 32'h0);
        check({tag, "_instr"}, instruction_out, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset       = 1'b1;
        stall_in    = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        vecs[0] = '{1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0044, 32'h2400_0040, 32'h0000_0044};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0084, 32'h2400_0080, 32'h0000_0084};
        vecs[2] = '{2, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h2400_0100, 32'h0000_0104};
        vecs[3] = '{1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hDBFF_FFFC, 32'h0000_0000};
        vecs[4] = '{2, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0204, 32'h2400_0200, 32'h0000_0204};

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset_imem_req", {31'h0, imem_req}, 32'h1);
        check("reset_imem_addr", imem_addr, 32'h0);

        // Sequential fetch from reset, then a 3-cycle stall on the second word.
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_out.push_back('{32'h4, 32'h2001_0005});
        exp_out.push_back('{32'h8, 32'h2002_0003});
        reset = 1'b0;
        repeat (3) step();
        stall_in = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            check("hold_valid", {31'h0, valid_out}, 32'h1);
            check("hold_pc4", pc_plus4_out, 32'h8);
            check("hold_instr", instruction_out, 32'h2002_0003);
            check("hold_no_req", {31'h0, imem_req}, 32'h0);
            if (c < 2) step();
        end
        stall_in = 1'b0;
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        exp_out.push_back('{32'hC, 32'h2400_0008});
        step();
        check_zero("resume");
        check("resume_req", {31'h0, imem_req}, 32'h1);
        drain();

        // Branch vectors: redirect from REQ or WAIT, with/without stall, latency 1 or 2.
        for (int i = 0; i < 5; i++) begin
            mem_lat = vecs[i].lat;
            found   = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                if (imem_req) found = 1'b1;
                else step();
            end
            check("br_wait_req", {31'h0, found}, 32'h1);
            if (!vecs[i].in_req) step();
            br_taken  = 1'b1;
            br_target = vecs[i].target;
            stall_in  = vecs[i].stall;
            step();
            br_taken = 1'b0;
            stall_in = 1'b0;
            check_zero("br_flush");
            exp_addr.push_back(vecs[i].target);
            exp_addr.push_back(vecs[i].exp_next);
            exp_out.push_back('{vecs[i].exp_pc4, vecs[i].exp_instr});
            drain();
        end

        // Async reset while waiting on a fetch at pc=0x10.
        mem_lat   = 1;
        br_taken  = 1'b1;
        br_target = 32'h10;
        step();
        br_taken = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
            else step();
        end
        check("rst_wait_req10", {31'h0, found}, 32'h1);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        check("async_rst_req", {31'h0, imem_req}, 32'h1);
        check("async_rst_addr", imem_addr, 32'h0);
        step();
        step();
        reset = 1'b0;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_out.push_back('{32'h4, 32'h2001_0005});
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
